// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: types and constants shared by the pipelined RV32 controller.
//   - opcode constants for instr[6:2]
//   - alu_op_e ALU operation encoding and the funct3 -> ALU op helper
//   - per-stage control bundles (ex_ctrl_t, mem_ctrl_t, wb_ctrl_t) and the full
//     decoded bundle ctrl_t
//   - forwarding select codes and the halt FSM state enum
package riscv_ctrl_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [1:0] FwdRf  = 2'b00;
    localparam logic [1:0] FwdMem = 2'b01;
    localparam logic [1:0] FwdWb  = 2'b10;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    beq;
        logic    bne;
        logic    jal;
        logic    jalr;
        logic    uret;
        logic    ecall;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_write;
        logic mem_half;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic csr;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
        logic      rs2_used;
    } ctrl_t;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } state_e;

    // alt is instr[30]; it selects SUB only for register-register ops, since in
    // OP-IMM that bit is part of the immediate (except for srai).
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                           input logic is_reg);
        alu_op_e res;
        unique case (f3)
            3'b000:  res = (alt && is_reg) ? AluSub : AluAdd;
            3'b001:  res = AluSll;
            3'b010:  res = AluSlt;
            3'b011:  res = AluSltu;
            3'b100:  res = AluXor;
            3'b101:  res = alt ? AluSra : AluSrl;
            3'b110:  res = AluOr;
            default: res = AluAnd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// riscv_ctrl_decode: purely combinational RV32 control decode.
// Config macro: RISCV_PIPE_CTRL_CSR_EN enables CSR and uret decode; without it
// every SYSTEM instruction decodes as ecall and ir21 is ignored.
// Ports:
//   op    instr[6:2]
//   funct {instr[30], instr[25], instr[14:12]}
//   ir21  instr[21]
//   ctrl  full control bundle (EX/MEM/WB sub-bundles plus rs2-used flag)
module riscv_ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [4:0] op,
    input  logic [4:0] funct,
    input  logic       ir21,
    output ctrl_t      ctrl
);

    logic [2:0] f3;
    logic       alt;

    assign f3  = funct[2:0];
    assign alt = funct[4];

    // instr[25] (M extension select) is not decoded by this controller.
`ifdef RISCV_PIPE_CTRL_CSR_EN
    logic unused_decode;
    assign unused_decode = funct[3];
`else
    logic unused_decode;
    assign unused_decode = ^{funct[3], ir21};
`endif

    always_comb begin
        ctrl = '0;
        case (op)
            OP_R: begin
                ctrl.ex.alu_op    = alu_decode(f3, alt, 1'b1);
                ctrl.wb.reg_write = 1'b1;
                ctrl.rs2_used     = 1'b1;
            end
            OP_I: begin
                ctrl.ex.alu_op    = alu_decode(f3, alt, 1'b0);
                ctrl.ex.alu_src   = 1'b1;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_LOAD: begin
                ctrl.ex.alu_src    = 1'b1;
                ctrl.mem.mem_half  = (f3[1:0] == 2'b01);
                ctrl.wb.reg_write  = 1'b1;
                ctrl.wb.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                ctrl.ex.alu_src    = 1'b1;
                ctrl.mem.mem_write = 1'b1;
                ctrl.mem.mem_half  = (f3[1:0] == 2'b01);
                ctrl.rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.ex.alu_op = AluSub;
                ctrl.ex.beq    = (f3 == 3'b000);
                ctrl.ex.bne    = (f3 == 3'b001);
                ctrl.rs2_used  = 1'b1;
            end
            OP_JAL: begin
                ctrl.ex.jal       = 1'b1;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_JALR: begin
                ctrl.ex.jalr      = 1'b1;
                ctrl.ex.alu_src   = 1'b1;
                ctrl.wb.reg_write = 1'b1;
            end
            OP_SYSTEM: begin
`ifdef RISCV_PIPE_CTRL_CSR_EN
                if (f3 != 3'b000) begin
                    ctrl.wb.csr       = 1'b1;
                    ctrl.wb.reg_write = 1'b1;
                end else if (ir21) begin
                    ctrl.ex.uret = 1'b1;
                end else begin
                    ctrl.ex.ecall = 1'b1;
                end
`else
                ctrl.ex.ecall = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl: pipelined RV32 controller. Decodes the ID instruction, carries
// the control bundle through ID/EX, EX/MEM and MEM/WB registers, and produces
// load-use stall, redirect flush, EX operand-forwarding selects and an ecall
// halt/resume FSM.
// Config macro: RISCV_PIPE_CTRL_CSR_EN enables CSR/uret; when undefined ex_uret
// and wb_csr are tied to 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   id_valid, op, funct, ir21, rs1, rs2, rd   ID-stage instruction fields
//   br_taken              EX resolved a taken redirect
//   resume                pulse leaving HALT
//   stall_if, flush_id    IF/ID hold and invalidate
//   halted                FSM is in HALT
//   ex_*, fwd_a, fwd_b    EX-stage control and forwarding selects
//   mem_write, mem_half   MEM-stage control
//   wb_reg_write, wb_mem_to_reg, wb_csr, wb_rd   WB-stage control
module riscv_pipe_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned RA_W    = 5,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [4:0]         op,
    input  logic [4:0]         funct,
    input  logic               ir21,
    input  logic [RA_W-1:0]    rs1,
    input  logic [RA_W-1:0]    rs2,
    input  logic [RA_W-1:0]    rd,
    input  logic               br_taken,
    input  logic               resume,
    output logic               stall_if,
    output logic               flush_id,
    output logic               halted,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_beq,
    output logic               ex_bne,
    output logic               ex_jal,
    output logic               ex_jalr,
    output logic               ex_uret,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               mem_write,
    output logic               mem_half,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic               wb_csr,
    output logic [RA_W-1:0]    wb_rd
);

    ctrl_t dec_raw;
    ctrl_t id_ctrl;

    ex_ctrl_t        ex_q;
    mem_ctrl_t       ex_mem_q;
    wb_ctrl_t        ex_wb_q;
    logic [RA_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;

    mem_ctrl_t       mem_q;
    wb_ctrl_t        mem_wb_q;
    logic [RA_W-1:0] mem_rd_q;

    wb_ctrl_t        wb_q;
    logic [RA_W-1:0] wb_rd_q;

    state_e state_q, state_d;

    logic load_use, hold, redirect, id_bubble;

    riscv_ctrl_decode u_decode (
        .op    (op),
        .funct (funct),
        .ir21  (ir21),
        .ctrl  (dec_raw)
    );

    assign id_ctrl = id_valid ? dec_raw : '0;

`ifdef RISCV_PIPE_CTRL_CSR_EN
    assign redirect = br_taken | ex_q.uret;
    assign ex_uret  = ex_q.uret;
    assign wb_csr   = wb_q.csr;
`else
    logic unused_csr;
    assign unused_csr = ex_q.uret ^ wb_q.csr;
    assign redirect   = br_taken;
    assign ex_uret    = 1'b0;
    assign wb_csr     = 1'b0;
`endif

    assign load_use = ex_wb_q.mem_to_reg && (ex_rd_q != '0) && id_valid &&
                      ((ex_rd_q == rs1) || (id_ctrl.rs2_used && (ex_rd_q == rs2)));

    // An ecall in EX already holds ID so the following instruction survives the halt.
    assign hold      = ex_q.ecall || (state_q == StHalt);
    assign flush_id  = redirect;
    assign stall_if  = !redirect && (load_use || hold);
    assign id_bubble = load_use || redirect || hold || !id_valid;
    assign halted    = (state_q == StHalt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (ex_q.ecall) state_d = StHalt;
            StHalt:  if (resume) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // MEM beats WB: it holds the younger write to the same register.
    always_comb begin
        fwd_a = FwdRf;
        fwd_b = FwdRf;
        if (mem_wb_q.reg_write && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
            fwd_a = FwdMem;
        end else if (wb_q.reg_write && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
            fwd_a = FwdWb;
        end
        if (mem_wb_q.reg_write && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
            fwd_b = FwdMem;
        end else if (wb_q.reg_write && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
            fwd_b = FwdWb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            ex_q     <= '0;
            ex_mem_q <= '0;
            ex_wb_q  <= '0;
            ex_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            mem_q    <= '0;
            mem_wb_q <= '0;
            mem_rd_q <= '0;
            wb_q     <= '0;
            wb_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            if (id_bubble) begin
                ex_q     <= '0;
                ex_mem_q <= '0;
                ex_wb_q  <= '0;
                ex_rd_q  <= '0;
                ex_rs1_q <= '0;
                ex_rs2_q <= '0;
            end else begin
                ex_q     <= id_ctrl.ex;
                ex_mem_q <= id_ctrl.mem;
                ex_wb_q  <= id_ctrl.wb;
                ex_rd_q  <= rd;
                ex_rs1_q <= rs1;
                ex_rs2_q <= rs2;
            end
            mem_q    <= ex_mem_q;
            mem_wb_q <= ex_wb_q;
            mem_rd_q <= ex_rd_q;
            wb_q     <= mem_wb_q;
            wb_rd_q  <= mem_rd_q;
        end
    end

    assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_beq        = ex_q.beq;
    assign ex_bne        = ex_q.bne;
    assign ex_jal        = ex_q.jal;
    assign ex_jalr       = ex_q.jalr;
    assign mem_write     = mem_q.mem_write;
    assign mem_half      = mem_q.mem_half;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// tb_riscv_pipe_ctrl: self-checking bench for riscv_pipe_ctrl. A decode table is
// streamed through the pipe with per-stage expectations held in scoreboard
// queues; hand-written sequences cover hazards, flush, halt and reset.
module tb_riscv_pipe_ctrl;

    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_I      = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] op, funct, rs1, rs2, rd;
    logic       ir21, br_taken, resume;
    logic       stall_if, flush_id, halted;
    logic [3:0] ex_alu_op;
    logic       ex_alu_src, ex_beq, ex_bne, ex_jal, ex_jalr, ex_uret;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_write, mem_half, wb_reg_write, wb_mem_to_reg, wb_csr;
    logic [4:0] wb_rd;
    logic [31:0] outs;

    int checks = 0;
    int failures = 0;

    // flags = {alu_src, beq, bne, jal, jalr, mem_write, mem_half, reg_write, mem_to_reg}
    typedef struct {
        string      nm;
        logic       valid;
        logic [4:0] op;
        logic [4:0] funct;
        logic [3:0] alu;
        logic [8:0] flags;
    } vec_t;

    typedef struct {
        string      nm;
        logic [3:0] alu;
        logic [8:0] flags;
        logic [4:0] rd;
    } exp_t;

    vec_t vecs[18];
    exp_t ex_sb[$];
    exp_t mem_sb[$];
    exp_t wb_sb[$];

    riscv_pipe_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .op            (op),
        .funct         (funct),
        .ir21          (ir21),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .br_taken      (br_taken),
        .resume        (resume),
        .stall_if      (stall_if),
        .flush_id      (flush_id),
        .halted        (halted),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_beq        (ex_beq),
        .ex_bne        (ex_bne),
        .ex_jal        (ex_jal),
        .ex_jalr       (ex_jalr),
        .ex_uret       (ex_uret),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mem_write     (mem_write),
        .mem_half      (mem_half),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_csr        (wb_csr),
        .wb_rd         (wb_rd)
    );

    always #5 clk = ~clk;

    assign outs = {5'd0, stall_if, flush_id, halted, ex_alu_op, ex_alu_src, ex_beq, ex_bne,
                   ex_jal, ex_jalr, ex_uret, fwd_a, fwd_b, mem_write, mem_half, wb_reg_write,
                   wb_mem_to_reg, wb_csr, wb_rd};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic [4:0] f,
                         input logic i21, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2);
        id_valid = v;
        op       = o;
        funct    = f;
        ir21     = i21;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
    endtask

    task automatic bubble();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic v, input logic [4:0] o,
                                input logic [4:0] f, input logic [3:0] alu,
                                input logic [8:0] flags);
        vec_t r;
        r.nm    = nm;
        r.valid = v;
        r.op    = o;
        r.funct = f;
        r.alu   = alu;
        r.flags = flags;
        return r;
    endfunction

    // Oldest stage first so an entry moves exactly one stage per call.
    task automatic sb_check();
        exp_t e;
        if (wb_sb.size() != 0) begin
            e = wb_sb.pop_front();
            chk({e.nm, "/wb"}, 32'({wb_reg_write, wb_mem_to_reg, wb_csr, wb_rd}),
                32'({e.flags[1], e.flags[0], 1'b0, e.rd}));
        end
        if (mem_sb.size() != 0) begin
            e = mem_sb.pop_front();
            chk({e.nm, "/mem"}, 32'({mem_write, mem_half}), 32'(e.flags[3:2]));
            wb_sb.push_back(e);
        end
        if (ex_sb.size() != 0) begin
            e = ex_sb.pop_front();
            chk({e.nm, "/ex"},
                32'({ex_alu_op, ex_alu_src, ex_beq, ex_bne, ex_jal, ex_jalr, ex_uret}),
                32'({e.alu, e.flags[8:4], 1'b0}));
            mem_sb.push_back(e);
        end
    endtask

    initial begin
        exp_t e;

        vecs[0]  = mk("add",       1'b1, OPC_R,      5'b00000, 4'd0, 9'b0_0000_00_10);
        vecs[1]  = mk("sub",       1'b1, OPC_R,      5'b10000, 4'd1, 9'b0_0000_00_10);
        vecs[2]  = mk("sra",       1'b1, OPC_R,      5'b10101, 4'd7, 9'b0_0000_00_10);
        vecs[3]  = mk("and",       1'b1, OPC_R,      5'b00111, 4'd9, 9'b0_0000_00_10);
        vecs[4]  = mk("addi",      1'b1, OPC_I,      5'b00000, 4'd0, 9'b1_0000_00_10);
        vecs[5]  = mk("addi_b30",  1'b1, OPC_I,      5'b10000, 4'd0, 9'b1_0000_00_10);
        vecs[6]  = mk("srli",      1'b1, OPC_I,      5'b00101, 4'd6, 9'b1_0000_00_10);
        vecs[7]  = mk("srai",      1'b1, OPC_I,      5'b10101, 4'd7, 9'b1_0000_00_10);
        vecs[8]  = mk("slti",      1'b1, OPC_I,      5'b00010, 4'd3, 9'b1_0000_00_10);
        vecs[9]  = mk("lw",        1'b1, OPC_LOAD,   5'b00010, 4'd0, 9'b1_0000_00_11);
        vecs[10] = mk("lh",        1'b1, OPC_LOAD,   5'b00001, 4'd0, 9'b1_0000_01_11);
        vecs[11] = mk("sw",        1'b1, OPC_STORE,  5'b00010, 4'd0, 9'b1_0000_10_00);
        vecs[12] = mk("sh",        1'b1, OPC_STORE,  5'b00001, 4'd0, 9'b1_0000_11_00);
        vecs[13] = mk("beq",       1'b1, OPC_BRANCH, 5'b00000, 4'd1, 9'b0_1000_00_00);
        vecs[14] = mk("bne",       1'b1, OPC_BRANCH, 5'b00001, 4'd1, 9'b0_0100_00_00);
        vecs[15] = mk("jal",       1'b1, OPC_JAL,    5'b00000, 4'd0, 9'b0_0010_00_10);
        vecs[16] = mk("jalr",      1'b1, OPC_JALR,   5'b00000, 4'd0, 9'b1_0001_00_10);
        vecs[17] = mk("add_inval", 1'b0, OPC_R,      5'b10000, 4'd0, 9'b0_0000_00_00);

        rst_n    = 1'b0;
        br_taken = 1'b0;
        resume   = 1'b0;
        bubble();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", outs, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_outputs", outs, 32'd0);

        // Decode table through the whole pipe; rd never matches rs1/rs2.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].funct, 1'b0, 5'(i + 3), 5'd1, 5'd2);
            e.nm    = vecs[i].nm;
            e.alu   = vecs[i].alu;
            e.flags = vecs[i].flags;
            e.rd    = vecs[i].valid ? 5'(i + 3) : 5'd0;
            ex_sb.push_back(e);
            #1;
            chk({vecs[i].nm, "/no_stall"}, 32'({stall_if, flush_id}), 32'd0);
            tick();
            sb_check();
        end
        for (int i = 0; i < 5; i++) begin
            bubble();
            if (i < 3) begin
                e.nm    = "drain";
                e.alu   = 4'd0;
                e.flags = 9'd0;
                e.rd    = 5'd0;
                ex_sb.push_back(e);
            end
            tick();
            sb_check();
        end

        // Load-use: lw x5,0(x1); add x6,x5,x2.
        drive(1'b1, OPC_LOAD, 5'b00010, 1'b0, 5'd5, 5'd1, 5'd0);
        tick();
        drive(1'b1, OPC_R, 5'b00000, 1'b0, 5'd6, 5'd5, 5'd2);
        #1;
        chk("lu_stall", 32'(stall_if), 32'd1);
        chk("lu_flush", 32'(flush_id), 32'd0);
        tick();
        #1;
        chk("lu_stall_one_cycle", 32'(stall_if), 32'd0);
        tick();
        bubble();
        #1;
        chk("lu_fwd", 32'({fwd_a, fwd_b}), 32'({2'b10, 2'b00}));
        chk("lu_wb_load", 32'({wb_mem_to_reg, wb_rd}), 32'({1'b1, 5'd5}));
        tick();
        chk("lu_bubble_in_wb", 32'(wb_reg_write), 32'd0);
        tick();
        chk("lu_add_in_wb", 32'({wb_reg_write, wb_rd}), 32'({1'b1, 5'd6}));

        // Forwarding: add x3; add x3; sub x4,x3,x3; or x7,x3,x4.
        drive(1'b1, OPC_R, 5'b00000, 1'b0, 5'd3, 5'd1, 5'd2);
        tick();
        drive(1'b1, OPC_R, 5'b00000, 1'b0, 5'd3, 5'd1, 5'd2);
        #1;
        chk("fw_no_stall", 32'(stall_if), 32'd0);
        tick();
        chk("fw_unrelated", 32'({fwd_a, fwd_b}), 32'd0);
        drive(1'b1, OPC_R, 5'b10000, 1'b0, 5'd4, 5'd3, 5'd3);
        tick();
        chk("fw_mem_priority", 32'({fwd_a, fwd_b}), 32'({2'b01, 2'b01}));
        chk("fw_sub_op", 32'(ex_alu_op), 32'd1);
        drive(1'b1, OPC_R, 5'b00110, 1'b0, 5'd7, 5'd3, 5'd4);
        tick();
        chk("fw_wb_and_mem", 32'({fwd_a, fwd_b}), 32'({2'b10, 2'b01}));
        bubble();
        repeat (3) tick();

        // Taken branch while a load-use hazard is pending in ID.
        drive(1'b1, OPC_LOAD, 5'b00010, 1'b0, 5'd5, 5'd1, 5'd0);
        tick();
        drive(1'b1, OPC_I, 5'b00000, 1'b0, 5'd6, 5'd5, 5'd0);
        br_taken = 1'b1;
        #1;
        chk("fl_flush", 32'(flush_id), 32'd1);
        chk("fl_no_stall", 32'(stall_if), 32'd0);
        tick();
        br_taken = 1'b0;
        bubble();
        chk("fl_ex_bubble", 32'({ex_alu_src, ex_alu_op}), 32'd0);
        #1;
        chk("fl_flush_drop", 32'(flush_id), 32'd0);
        repeat (3) tick();

        // Load into x0 then a use of x0.
        drive(1'b1, OPC_LOAD, 5'b00010, 1'b0, 5'd0, 5'd1, 5'd0);
        tick();
        drive(1'b1, OPC_R, 5'b00000, 1'b0, 5'd6, 5'd0, 5'd0);
        #1;
        chk("x0_no_stall", 32'(stall_if), 32'd0);
        tick();
        bubble();
        chk("x0_no_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        repeat (3) tick();

        // ecall then addi x8,x0,5; resume.
        drive(1'b1, OPC_SYSTEM, 5'b00000, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, OPC_I, 5'b00000, 1'b0, 5'd8, 5'd0, 5'd0);
        #1;
        chk("ec_not_yet_halted", 32'(halted), 32'd0);
        tick();
        chk("ec_halted", 32'(halted), 32'd1);
        chk("ec_stall", 32'(stall_if), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ec_halt_held", 32'({halted, stall_if, ex_alu_src}), 32'({1'b1, 1'b1, 1'b0}));
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("ec_resumed", 32'(halted), 32'd0);
        tick();
        bubble();
        chk("ec_addi_in_ex", 32'(ex_alu_src), 32'd1);
        tick();
        tick();
        chk("ec_addi_in_wb", 32'({wb_reg_write, wb_rd}), 32'({1'b1, 5'd8}));
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_in_run", 32'(halted), 32'd0);

        // Reset while halted.
        drive(1'b1, OPC_SYSTEM, 5'b00000, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        bubble();
        tick();
        chk("rh_halted", 32'(halted), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rh_async_reset", outs, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rh_run_after_reset", 32'({halted, stall_if}), 32'd0);

        // uret: SYSTEM with ir21=1.
        drive(1'b1, OPC_SYSTEM, 5'b00000, 1'b1, 5'd0, 5'd0, 5'd0);
        tick();
        bubble();
        #1;
`ifdef RISCV_PIPE_CTRL_CSR_EN
        chk("uret_ex", 32'({ex_uret, flush_id, stall_if}), 32'({1'b1, 1'b1, 1'b0}));
        tick();
        chk("uret_no_halt", 32'({halted, ex_uret}), 32'd0);
        drive(1'b1, OPC_SYSTEM, 5'b00001, 1'b0, 5'd10, 5'd1, 5'd0);
        tick();
        bubble();
        tick();
        tick();
        chk("csr_wb", 32'({wb_csr, wb_reg_write, wb_rd}), 32'({1'b1, 1'b1, 5'd10}));
`else
        chk("uret_as_ecall", 32'({ex_uret, flush_id, stall_if}), 32'({1'b0, 1'b0, 1'b1}));
        tick();
        chk("uret_halts", 32'(halted), 32'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("uret_resume", 32'(halted), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_pipe_ctrl.md
# riscv_pipe_ctrl

Pipelined successor to the single-cycle RV32 controller. Decodes the ID-stage instruction into the same control signal set, then carries the control bundle through EX/MEM/WB pipeline registers. Performs load-use stall detection, taken-branch/jump flush, EX-stage operand-forwarding selection, and an ecall halt/resume state machine. Sits between the IF/ID register and the datapath pipeline registers; the datapath consumes its per-stage outputs.

## Interface
- `RA_W`, 5, register address width
- `ALUOP_W`, 4, ALU operation code width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: IF/ID register holds a real instruction
- `op` in 5: instr[6:2]
- `funct` in 5: {instr[30], instr[25], instr[14:12]}, MSB first
- `ir21` in 1: instr[21]
- `rs1`, `rs2`, `rd` in RA_W: ID register addresses
- `br_taken` in 1: EX resolved a taken beq/bne, or jal/jalr is in EX
- `resume` in 1: single-cycle pulse leaving HALT
- `stall_if` out 1: hold PC and IF/ID
- `flush_id` out 1: invalidate IF/ID
- `halted` out 1: state is HALT
- `ex_alu_op` out ALUOP_W
- `ex_alu_src`, `ex_beq`, `ex_bne`, `ex_jal`, `ex_jalr`, `ex_uret` out 1
- `fwd_a`, `fwd_b` out 2: 00 register file, 01 MEM result, 10 WB result
- `mem_write`, `mem_half` out 1: MEM stage
- `wb_reg_write`, `wb_mem_to_reg`, `wb_csr` out 1: WB stage
- `wb_rd` out RA_W

## Operation
- Decode is combinational from op/funct/ir21, using the existing single-cycle rules (S_type, half, Beq, Bne, JAL, Jalr, CSR, ecall, uret). The result is gated by `id_valid`.
- ID→EX register: captures the decoded bundle plus rd/rs1/rs2. It loads a bubble (all control 0, rd=0) on load-use stall, flush, or HALT.
- EX→MEM and MEM→WB: plain shift of the relevant sub-bundle every cycle. Never stalled.
- Load-use stall, asserted when all hold:
  - EX has mem_to_reg=1
  - ex_rd≠0
  - ex_rd equals rs1, or equals rs2 when the ID instruction reads rs2
  - id_valid=1
  - Effect: `stall_if`=1 for exactly one cycle, and a bubble enters EX.
- Flush: `br_taken` causes `flush_id`=1 in the same cycle and a bubble into EX on the next edge. `flush_id` has priority over a load-use stall in the same cycle.
- Forwarding (for each of rs1/rs2 in EX):
  - 01 if MEM reg_write=1, mem_rd≠0, and mem_rd matches.
  - Else 10 if WB reg_write=1, wb_rd≠0, and wb_rd matches.
  - Else 00. MEM takes priority over WB.
- Halt FSM:
  - States: RUN, HALT.
  - RUN→HALT: at the edge where a valid ecall occupies EX.
  - HALT: `stall_if`=1, bubbles into EX, and MEM/WB drain normally.
  - HALT→RUN: on `resume`. `resume` while in RUN is ignored.
  - A `br_taken` in the same cycle as an ecall in EX cannot occur, because ecall never asserts it.

## Timing
- Decode to EX outputs: 1 cycle. MEM outputs: 2 cycles. WB outputs: 3 cycles.
- `stall_if`, `flush_id` and `fwd_*` are combinational from registered state plus ID inputs and `br_taken`.
- `halted` is registered and rises on the cycle after the ecall leaves EX.
- Reset (asynchronous assert, synchronous-safe deassert at the next edge): all pipeline registers are bubbles, state is RUN, and every output is 0.
- A reset mid-halt returns to RUN with an empty pipe.

## Configuration
- `RISCV_PIPE_CTRL_CSR_EN` defined: CSR and uret are decoded. uret (SYSTEM, ir21=1) sets `ex_uret` and is treated as a taken redirect: `flush_id` is asserted while it is in EX. `wb_csr` is carried through the pipeline.
- `RISCV_PIPE_CTRL_CSR_EN` undefined: `ex_uret` and `wb_csr` are tied to 0, and ir21 is ignored. Every SYSTEM instruction decodes as ecall.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants (OP_R=01100, OP_I=00100, OP_LOAD=00000, OP_STORE=01000, OP_BRANCH=11000, OP_JAL=11011, OP_JALR=11001, OP_SYSTEM=11100)
  - the `alu_op_e` encoding
  - packed bundle typedefs `ex_ctrl_t`, `mem_ctrl_t`, `wb_ctrl_t`
  - the state enum
- Sub-module `riscv_ctrl_decode`: purely combinational decode from op/funct/ir21 to a full bundle.

## Test plan
- `lw x5,0(x1)` followed by `add x6,x5,x2` → `stall_if`=1 for exactly one cycle, then `fwd_a`=10 when the add reaches EX.
- `add x3,x1,x2` followed by `sub x4,x3,x3` → `fwd_a`=01 and `fwd_b`=01, with no stall.
- `beq` with `br_taken`=1 in EX while a load-use hazard is pending in ID → `flush_id`=1, `stall_if`=0, and EX holds a bubble next cycle.
- Load to x0 followed by a use of x0 → no stall, and `fwd_*`=00.
- ecall followed by `addi` → `halted`=1 two edges after ecall issue and stays held. A `resume` pulse → RUN, and the `addi` reaches WB with `wb_reg_write`=1.
- uret with the macro defined → `ex_uret`=1 and `flush_id`=1. With the macro undefined → the same instruction halts.
